// File: rtl/bellek_pkg.sv
// Shared constants for the main-memory arbiter and its requesters.
package bellek_pkg;

  localparam int unsigned ADRES_BIT = 32;
  localparam int unsigned VERI_BIT  = 32;

  localparam logic [31:0] BELLEK_ADRES = 32'h8000_0000;

  localparam logic P_ISLEMCI   = 1'b0;
  localparam logic P_YUKLEYICI = 1'b1;

endpackage

// File: rtl/bellek_hakemi_if.sv
// One requester port of the memory arbiter: request, address/data, lock and ready.
interface bellek_hakemi_if
  import bellek_pkg::*;
#(
  parameter int unsigned ADRES_BIT = bellek_pkg::ADRES_BIT,
  parameter int unsigned VERI_BIT  = bellek_pkg::VERI_BIT
) ();

  logic                 istek;
  logic [ADRES_BIT-1:0] adres;
  logic                 yaz;
  logic [VERI_BIT-1:0]  yaz_veri;
  logic                 kilit;
  logic                 hazir;
  logic [VERI_BIT-1:0]  oku_veri;

  modport master (
    output istek, adres, yaz, yaz_veri, kilit,
    input  hazir, oku_veri
  );

  modport slave (
    input  istek, adres, yaz, yaz_veri, kilit,
    output hazir, oku_veri
  );

endinterface

// File: rtl/hakem_rr2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last time wins.
module hakem_rr2
  import bellek_pkg::*;
(
  input  logic [1:0] istek,
  input  logic       son_kazanan,
  output logic       gecerli_c,
  output logic       kazanan_c
);

  // Pick the single requester, or the one that was not the last winner on a tie
  always_comb begin
    gecerli_c = |istek;
    kazanan_c = P_ISLEMCI;
    case (istek)
      2'b10:   kazanan_c = P_YUKLEYICI;
      2'b11:   kazanan_c = ~son_kazanan;
      default: kazanan_c = P_ISLEMCI;
    endcase
  end

endmodule

// File: rtl/bellek_hakemi.sv
// Arbiter for the single-port main memory shared by the processor (port 0) and the
// loader/debug master (port 1). One access per cycle, zero-latency grant, round-robin
// on conflict. Optional burst lock is built when BELLEK_HAKEMI_KILIT_EN is defined.
module bellek_hakemi
  import bellek_pkg::*;
#(
  parameter int unsigned ADRES_BIT = bellek_pkg::ADRES_BIT,
  parameter int unsigned VERI_BIT  = bellek_pkg::VERI_BIT,
  parameter int unsigned MAX_KILIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bellek_hakemi_if.slave       p0,
  bellek_hakemi_if.slave       p1,
  output logic [ADRES_BIT-1:0] bellek_adres,
  output logic [VERI_BIT-1:0]  bellek_yaz_veri,
  output logic                 bellek_yaz,
  input  logic [VERI_BIT-1:0]  bellek_oku_veri
);

  if (MAX_KILIT < 1) begin : g_max_kilit_hata
    $error("MAX_KILIT must be at least 1");
  end

  logic [1:0] istek_c;
  logic       rr_gecerli_c;
  logic       rr_kazanan_c;
  logic       izin_gecerli_c;
  logic       izin_c;
  logic       son_kazanan_q;
  logic       son_kazanan_d;

  // Requests are masked during reset so nothing is granted or written
  assign istek_c = {p1.istek, p0.istek} & {2{~rst}};

  hakem_rr2 u_rr (
    .istek       (istek_c),
    .son_kazanan (son_kazanan_q),
    .gecerli_c   (rr_gecerli_c),
    .kazanan_c   (rr_kazanan_c)
  );

`ifdef BELLEK_HAKEMI_KILIT_EN
  localparam int unsigned SAYAC_BIT = $clog2(MAX_KILIT + 1);

  logic                 kilit_gecerli_q, kilit_gecerli_d;
  logic                 kilit_sahibi_q,  kilit_sahibi_d;
  logic [SAYAC_BIT-1:0] kilit_sayac_q,   kilit_sayac_d;
  logic                 kilit_doldu_c;
  logic                 kilit_aktif_c;
  logic                 kilit_istek_c;

  // Lock override on top of the round-robin pick, and next lock state
  always_comb begin
    kilit_doldu_c   = kilit_gecerli_q && (kilit_sayac_q == SAYAC_BIT'(MAX_KILIT));
    kilit_aktif_c   = kilit_gecerli_q && !kilit_doldu_c && istek_c[kilit_sahibi_q];
    izin_gecerli_c  = rr_gecerli_c;
    izin_c          = rr_kazanan_c;
    kilit_gecerli_d = 1'b0;
    kilit_sahibi_d  = kilit_sahibi_q;
    kilit_sayac_d   = '0;

    if (kilit_aktif_c) begin
      izin_gecerli_c = 1'b1;
      izin_c         = kilit_sahibi_q;
    end

    kilit_istek_c = (izin_c == P_YUKLEYICI) ? p1.kilit : p0.kilit;

    // An expiring owner cannot re-lock in the same cycle; the count restarts on its next grant
    if (izin_gecerli_c && kilit_istek_c &&
        !(kilit_doldu_c && (kilit_sahibi_q == izin_c))) begin
      kilit_gecerli_d = 1'b1;
      kilit_sahibi_d  = izin_c;
      kilit_sayac_d   = kilit_aktif_c ? (kilit_sayac_q + SAYAC_BIT'(1)) : SAYAC_BIT'(1);
    end
  end

  // Lock state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      kilit_gecerli_q <= 1'b0;
      kilit_sahibi_q  <= P_ISLEMCI;
      kilit_sayac_q   <= '0;
    end else begin
      kilit_gecerli_q <= kilit_gecerli_d;
      kilit_sahibi_q  <= kilit_sahibi_d;
      kilit_sayac_q   <= kilit_sayac_d;
    end
  end
`else
  logic kilit_unused;

  assign kilit_unused   = p0.kilit ^ p1.kilit;
  assign izin_gecerli_c = rr_gecerli_c;
  assign izin_c         = rr_kazanan_c;
`endif

  // Steer the granted port onto the memory bus and raise its ready
  always_comb begin
    son_kazanan_d   = son_kazanan_q;
    p0.hazir        = 1'b0;
    p1.hazir        = 1'b0;
    bellek_adres    = '0;
    bellek_yaz_veri = '0;
    bellek_yaz      = 1'b0;
    if (izin_gecerli_c) begin
      son_kazanan_d = izin_c;
      if (izin_c == P_YUKLEYICI) begin
        p1.hazir        = 1'b1;
        bellek_adres    = p1.adres;
        bellek_yaz_veri = p1.yaz_veri;
        bellek_yaz      = p1.yaz;
      end else begin
        p0.hazir        = 1'b1;
        bellek_adres    = p0.adres;
        bellek_yaz_veri = p0.yaz_veri;
        bellek_yaz      = p0.yaz;
      end
    end
  end

  // Read data is broadcast; each requester qualifies it with its own ready
  assign p0.oku_veri = bellek_oku_veri;
  assign p1.oku_veri = bellek_oku_veri;

  // Last-winner register; reset to port 1 so port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      son_kazanan_q <= P_YUKLEYICI;
    end else begin
      son_kazanan_q <= son_kazanan_d;
    end
  end

endmodule

// File: tb/tb_bellek_hakemi.sv
// Directed bench for bellek_hakemi with a small combinational-read memory model.
module tb_bellek_hakemi;
  import bellek_pkg::*;

  localparam int unsigned MAXK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bellek_adres;
  logic [31:0] bellek_yaz_veri;
  logic        bellek_yaz;
  logic [31:0] bellek_oku_veri;

  int n_toplam = 0;
  int n_gecti  = 0;

  bellek_hakemi_if #(.ADRES_BIT(ADRES_BIT), .VERI_BIT(VERI_BIT)) p0_if ();
  bellek_hakemi_if #(.ADRES_BIT(ADRES_BIT), .VERI_BIT(VERI_BIT)) p1_if ();

  bellek_hakemi #(
    .ADRES_BIT (ADRES_BIT),
    .VERI_BIT  (VERI_BIT),
    .MAX_KILIT (MAXK)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .p0              (p0_if),
    .p1              (p1_if),
    .bellek_adres    (bellek_adres),
    .bellek_yaz_veri (bellek_yaz_veri),
    .bellek_yaz      (bellek_yaz),
    .bellek_oku_veri (bellek_oku_veri)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write at the rising edge
  logic [31:0] mem [64];
  logic        mem_yuklu = 1'b0;

  assign bellek_oku_veri = mem[bellek_adres[7:2]];

  always @(posedge clk) begin
    if (!mem_yuklu) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0]    <= 32'h0050_0293;
      mem_yuklu <= 1'b1;
    end else if (bellek_yaz) begin
      mem[bellek_adres[7:2]] <= bellek_yaz_veri;
    end
  end

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    n_toplam++;
    if (gozlenen === beklenen) n_gecti++;
    else $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
  endtask

  task automatic sur(input logic i0, input logic k0, input logic y0,
                     input logic [31:0] a0, input logic [31:0] d0,
                     input logic i1, input logic k1, input logic y1,
                     input logic [31:0] a1, input logic [31:0] d1);
    p0_if.istek = i0; p0_if.kilit = k0; p0_if.yaz = y0; p0_if.adres = a0; p0_if.yaz_veri = d0;
    p1_if.istek = i1; p1_if.kilit = k1; p1_if.yaz = y1; p1_if.adres = a1; p1_if.yaz_veri = d1;
  endtask

  task automatic ilerle();
    @(posedge clk);
    #1;
  endtask

  logic bek_p1_kilit [10];
  logic bek_p1_dus   [8];

  initial begin
`ifdef BELLEK_HAKEMI_KILIT_EN
    bek_p1_kilit = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bek_p1_dus   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    bek_p1_kilit = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bek_p1_dus   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

    // Reset held 10 cycles with both ports requesting writes
    rst = 1'b1;
    sur(1'b1, 1'b0, 1'b1, BELLEK_ADRES + 32'h10, 32'hDEAD_0010,
        1'b1, 1'b0, 1'b1, BELLEK_ADRES + 32'h14, 32'hDEAD_0014);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      kontrol("rst_hazir0", 32'(p0_if.hazir), 32'd0);
      kontrol("rst_hazir1", 32'(p1_if.hazir), 32'd0);
      kontrol("rst_yaz", 32'(bellek_yaz), 32'd0);
    end
    kontrol("rst_adres", bellek_adres, 32'h0);
    kontrol("rst_yaz_veri", bellek_yaz_veri, 32'h0);

    // First tie after reset goes to port 0
    ilerle();
    rst = 1'b0;
    sur(1'b1, 1'b0, 1'b0, BELLEK_ADRES, 32'h0, 1'b1, 1'b0, 1'b0, BELLEK_ADRES + 32'h4, 32'h0);
    @(negedge clk);
    kontrol("ilk_tie_hazir0", 32'(p0_if.hazir), 32'd1);
    kontrol("ilk_tie_hazir1", 32'(p1_if.hazir), 32'd0);
    kontrol("ilk_tie_adres", bellek_adres, BELLEK_ADRES);

    // Port 0 alone reads the first word
    ilerle();
    sur(1'b1, 1'b0, 1'b0, BELLEK_ADRES, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    kontrol("p0_oku_hazir0", 32'(p0_if.hazir), 32'd1);
    kontrol("p0_oku_veri", p0_if.oku_veri, 32'h0050_0293);
    kontrol("p0_oku_hazir1", 32'(p1_if.hazir), 32'd0);
    kontrol("p0_oku_yaz", 32'(bellek_yaz), 32'd0);

    // Port 1 alone reads the same word
    ilerle();
    sur(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, BELLEK_ADRES, 32'h0);
    @(negedge clk);
    kontrol("p1_oku_hazir1", 32'(p1_if.hazir), 32'd1);
    kontrol("p1_oku_veri", p1_if.oku_veri, 32'h0050_0293);
    kontrol("p1_oku_hazir0", 32'(p0_if.hazir), 32'd0);

    // Idle bus
    ilerle();
    sur(1'b0, 1'b0, 1'b0, BELLEK_ADRES, 32'h1, 1'b0, 1'b0, 1'b1, BELLEK_ADRES, 32'h2);
    @(negedge clk);
    kontrol("bos_hazir0", 32'(p0_if.hazir), 32'd0);
    kontrol("bos_hazir1", 32'(p1_if.hazir), 32'd0);
    kontrol("bos_adres", bellek_adres, 32'h0);
    kontrol("bos_yaz", 32'(bellek_yaz), 32'd0);

    // Both ports write continuously: grants alternate starting with port 0
    for (int c = 0; c < 6; c++) begin
      ilerle();
      sur(1'b1, 1'b0, 1'b1, BELLEK_ADRES + 32'h30, 32'hA5A5_0030,
          1'b1, 1'b0, 1'b1, BELLEK_ADRES + 32'h34, 32'h5A5A_0034);
      @(negedge clk);
      kontrol("rr_hazir0", 32'(p0_if.hazir), 32'((c % 2) == 0));
      kontrol("rr_hazir1", 32'(p1_if.hazir), 32'((c % 2) == 1));
      kontrol("rr_adres", bellek_adres,
              ((c % 2) == 0) ? BELLEK_ADRES + 32'h30 : BELLEK_ADRES + 32'h34);
      kontrol("rr_yaz", 32'(bellek_yaz), 32'd1);
    end
    ilerle();
    sur(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    kontrol("rr_mem_30", mem[12], 32'hA5A5_0030);
    kontrol("rr_mem_34", mem[13], 32'h5A5A_0034);

    // Single port 0 access so port 1 wins the next tie
    ilerle();
    sur(1'b1, 1'b0, 1'b0, BELLEK_ADRES, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    kontrol("hazirlik_hazir0", 32'(p0_if.hazir), 32'd1);

    // Port 1 requests with lock for 10 cycles while port 0 also requests
    for (int c = 0; c < 10; c++) begin
      ilerle();
      sur(1'b1, 1'b0, 1'b0, BELLEK_ADRES, 32'h0, 1'b1, 1'b1, 1'b0, BELLEK_ADRES + 32'h4, 32'h0);
      @(negedge clk);
      kontrol("kilit_hazir1", 32'(p1_if.hazir), 32'(bek_p1_kilit[c]));
      kontrol("kilit_hazir0", 32'(p0_if.hazir), 32'(!bek_p1_kilit[c]));
    end

    // Locked port 1 drops its request for one cycle; lock clears and restarts at 1
    for (int c = 0; c < 8; c++) begin
      ilerle();
      sur(1'b1, 1'b0, 1'b0, BELLEK_ADRES, 32'h0,
          (c != 2), 1'b1, 1'b0, BELLEK_ADRES + 32'h4, 32'h0);
      @(negedge clk);
      kontrol("dus_hazir1", 32'(p1_if.hazir), 32'(bek_p1_dus[c]));
      kontrol("dus_hazir0", 32'(p0_if.hazir), 32'(!bek_p1_dus[c]));
    end

    // Reset in the middle of a locked write burst from port 1
    for (int c = 0; c < 2; c++) begin
      ilerle();
      sur(1'b1, 1'b0, 1'b1, BELLEK_ADRES + 32'h3C, 32'h1111_003C,
          1'b1, 1'b1, 1'b1, BELLEK_ADRES + 32'h38, 32'h2222_0038 + 32'(c));
    end
    ilerle();
    rst = 1'b1;
    @(negedge clk);
    kontrol("rst_patlama_yaz", 32'(bellek_yaz), 32'd0);
    kontrol("rst_patlama_hazir0", 32'(p0_if.hazir), 32'd0);
    kontrol("rst_patlama_hazir1", 32'(p1_if.hazir), 32'd0);
    kontrol("rst_patlama_adres", bellek_adres, 32'h0);
    kontrol("rst_patlama_veri", bellek_yaz_veri, 32'h0);
    ilerle();
    rst = 1'b0;
    @(negedge clk);
    kontrol("rst_sonra_hazir0", 32'(p0_if.hazir), 32'd1);
    kontrol("rst_sonra_hazir1", 32'(p1_if.hazir), 32'd0);

    $display("%0d/%0d checks passed", n_gecti, n_toplam);
    $finish;
  end

endmodule
